// File: rtl/ball_renderer_pkg.sv
// Shared types and constants for the ball renderer: motion FSM encoding,
// coordinate width, colour constants and the colour-cycling helper.
package ball_renderer_pkg;

  localparam int CW = 12;
  localparam logic [2:0] COL_RESET  = 3'b001;
  localparam logic [2:0] BORDER_COL = 3'b111;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_MOVE   = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_WAIT   = 2'd3
  } motion_state_e;

  // Colour steps 001..111 and skips 000 so the ball never turns black.
  function automatic logic [2:0] next_col(input logic [2:0] c);
    return (c == 3'b111) ? 3'b001 : c + 3'd1;
  endfunction

endpackage

// File: rtl/ball_motion.sv
// Per-frame ball motion: on each vblank rising edge step the centre by the
// velocity, clamp and reflect at the walls, and advance the colour on a hit.
module ball_motion
  import ball_renderer_pkg::*;
#(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int RADIUS = 16,
  parameter int SPEED  = 2,
  parameter int X0     = 320,
  parameter int Y0     = 240
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          vblank_i,
  output logic [CW-1:0] pos_x_o,
  output logic [CW-1:0] pos_y_o,
  output logic [2:0]    col_o
);

  localparam logic signed [12:0] X_HI = 13'(HRES - 1 - RADIUS);
  localparam logic signed [12:0] Y_HI = 13'(VRES - 1 - RADIUS);
  localparam logic signed [12:0] LO   = 13'(RADIUS);
  localparam logic signed [4:0]  V0   = 5'(SPEED);

  motion_state_e      state_q, state_d;
  logic               vb_q;
  logic [CW-1:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [4:0]  vx_q, vx_d, vy_q, vy_d;
  logic signed [12:0] nx_q, nx_d, ny_q, ny_d;
  logic [2:0]         col_q, col_d;
  logic               hit_x, hit_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACTIVE;
      vb_q    <= 1'b1;
      pos_x_q <= CW'(X0);
      pos_y_q <= CW'(Y0);
      vx_q    <= V0;
      vy_q    <= V0;
      nx_q    <= '0;
      ny_q    <= '0;
      col_q   <= COL_RESET;
    end else begin
      state_q <= state_d;
      vb_q    <= vblank_i;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    col_d   = col_q;
    hit_x   = 1'b0;
    hit_y   = 1'b0;
    case (state_q)
      ST_ACTIVE: if (vblank_i && !vb_q) state_d = ST_MOVE;
      ST_MOVE: begin
        nx_d    = {1'b0, pos_x_q} + {{8{vx_q[4]}}, vx_q};
        ny_d    = {1'b0, pos_y_q} + {{8{vy_q[4]}}, vy_q};
        state_d = ST_BOUNCE;
      end
      ST_BOUNCE: begin
        if (nx_q >= X_HI) begin
          pos_x_d = X_HI[CW-1:0];
          vx_d    = -vx_q;
          hit_x   = 1'b1;
        end else if (nx_q <= LO) begin
          pos_x_d = LO[CW-1:0];
          vx_d    = -vx_q;
          hit_x   = 1'b1;
        end else begin
          pos_x_d = nx_q[CW-1:0];
        end
        if (ny_q >= Y_HI) begin
          pos_y_d = Y_HI[CW-1:0];
          vy_d    = -vy_q;
          hit_y   = 1'b1;
        end else if (ny_q <= LO) begin
          pos_y_d = LO[CW-1:0];
          vy_d    = -vy_q;
          hit_y   = 1'b1;
        end else begin
          pos_y_d = ny_q[CW-1:0];
        end
        // A corner touches both walls but advances the colour only once.
        if (hit_x || hit_y) col_d = next_col(col_q);
        state_d = ST_WAIT;
      end
      ST_WAIT: if (!vblank_i) state_d = ST_ACTIVE;
      default: state_d = ST_ACTIVE;
    endcase
  end

  assign pos_x_o = pos_x_q;
  assign pos_y_o = pos_y_q;
  assign col_o   = col_q;

endmodule

// File: rtl/ball_renderer.sv
// Bouncing-ball pixel stage: pixel counters, 3-stage distance pipeline and
// matching sync delay. Define BALL_BORDER_EN to draw a white frame border.
module ball_renderer
  import ball_renderer_pkg::*;
#(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int RADIUS = 16,
  parameter int SPEED  = 2,
  parameter int X0     = 320,
  parameter int Y0     = 240
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hsync,
  input  logic i_vsync,
  input  logic i_hblank,
  input  logic i_vblank,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_red,
  output logic o_grn,
  output logic o_blu
);

  localparam logic [24:0] R_SQ = 25'(RADIUS * RADIUS);

  logic [CW-1:0] pos_x, pos_y;
  logic [2:0]    col;

  ball_motion #(
    .HRES(HRES), .VRES(VRES), .RADIUS(RADIUS),
    .SPEED(SPEED), .X0(X0), .Y0(Y0)
  ) u_motion (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .vblank_i(i_vblank),
    .pos_x_o (pos_x),
    .pos_y_o (pos_y),
    .col_o   (col)
  );

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hb_q, hrise_q, hrise_d;
  logic [CW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [23:0]   dx2_q, dx2_d, dy2_q, dy2_d;
  logic          bl1_q, bl2_q, hs1_q, hs2_q, hs3_q, vs1_q, vs2_q, vs3_q;
  logic          brd1_q, brd1_d, brd2_q;
  logic [24:0]   dist_sq;
  logic [2:0]    rgb_q, rgb_d;

  // The x/y registers hold the coordinate of the pixel presented this cycle.
  always_comb begin
    x_d     = i_hblank ? '0 : x_q + 12'd1;
    hrise_d = i_hblank & ~hb_q;
    y_d     = y_q;
    if (i_vblank)     y_d = '0;
    else if (hrise_q) y_d = y_q + 12'd1;
  end

  always_comb begin
    dx_d  = (x_q >= pos_x) ? x_q - pos_x : pos_x - x_q;
    dy_d  = (y_q >= pos_y) ? y_q - pos_y : pos_y - y_q;
    dx2_d = {12'd0, dx_q} * {12'd0, dx_q};
    dy2_d = {12'd0, dy_q} * {12'd0, dy_q};
`ifdef BALL_BORDER_EN
    brd1_d = (x_q == '0) || (x_q == CW'(HRES - 1)) ||
             (y_q == '0) || (y_q == CW'(VRES - 1));
`else
    brd1_d = 1'b0;
`endif
  end

  assign dist_sq = {1'b0, dx2_q} + {1'b0, dy2_q};

  always_comb begin
    rgb_d = 3'b000;
    if (!bl2_q && (dist_sq <= R_SQ)) rgb_d = col;
`ifdef BALL_BORDER_EN
    if (!bl2_q && brd2_q) rgb_d = BORDER_COL;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      hb_q    <= 1'b1;
      hrise_q <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      dx2_q   <= '0;
      dy2_q   <= '0;
      bl1_q   <= 1'b1;
      bl2_q   <= 1'b1;
      brd1_q  <= 1'b0;
      brd2_q  <= 1'b0;
      hs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      hs3_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vs2_q   <= 1'b1;
      vs3_q   <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hb_q    <= i_hblank;
      hrise_q <= hrise_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      dx2_q   <= dx2_d;
      dy2_q   <= dy2_d;
      bl1_q   <= i_hblank | i_vblank;
      bl2_q   <= bl1_q;
      brd1_q  <= brd1_d;
      brd2_q  <= brd1_q;
      hs1_q   <= i_hsync;
      hs2_q   <= hs1_q;
      hs3_q   <= hs2_q;
      vs1_q   <= i_vsync;
      vs2_q   <= vs1_q;
      vs3_q   <= vs2_q;
      rgb_q   <= rgb_d;
    end
  end

  assign o_hsync = hs3_q;
  assign o_vsync = vs3_q;
  assign o_red   = rgb_q[2];
  assign o_grn   = rgb_q[1];
  assign o_blu   = rgb_q[0];

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: a default-size instance plus a 64x64
// instance whose ball moves diagonally so every wall hit is a corner.
module tb_ball_renderer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hsync = 1'b1, vsync = 1'b1, hblank = 1'b1, vblank = 1'b0;

  logic m_hsync, m_vsync, m_red, m_grn, m_blu;
  logic c_hsync, c_vsync, c_red, c_grn, c_blu;
  logic [2:0] m_rgb, c_rgb;
  assign m_rgb = {m_red, m_grn, m_blu};
  assign c_rgb = {c_red, c_grn, c_blu};

  int checks = 0;
  int errors = 0;
  int cur_y  = 0;
  logic [2:0] ml [0:1023];
  logic [2:0] cl [0:1023];

  always #5 clk = ~clk;

  ball_renderer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .i_hblank(hblank), .i_vblank(vblank), .o_hsync(m_hsync), .o_vsync(m_vsync),
    .o_red(m_red), .o_grn(m_grn), .o_blu(m_blu)
  );

  ball_renderer #(
    .HRES(64), .VRES(64), .RADIUS(4), .SPEED(2), .X0(30), .Y0(30)
  ) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .i_hblank(hblank), .i_vblank(vblank), .o_hsync(c_hsync), .o_vsync(c_vsync),
    .o_red(c_red), .o_grn(c_grn), .o_blu(c_blu)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quick_lines(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); hblank = 1'b0;
      tick(); hblank = 1'b1;
      tick(); tick();
    end
    cur_y = cur_y + n;
  endtask

  task automatic goto_line(input int ty);
    quick_lines(ty - cur_y);
  endtask

  // Drives one active line of len pixels; ml/cl[x] hold the colour of pixel x.
  task automatic scan_line(input int len);
    for (int i = 0; i < len + 3; i++) begin
      tick();
      hblank = (i < len) ? 1'b0 : 1'b1;
      if (i >= 3) begin
        ml[i-3] = m_rgb;
        cl[i-3] = c_rgb;
      end
    end
    tick(); tick(); tick();
    cur_y = cur_y + 1;
  endtask

  task automatic advance_frames(input int n);
    for (int f = 0; f < n; f++) begin
      tick(); vblank = 1'b1;
      repeat (4) tick();
      vblank = 1'b0;
      repeat (3) tick();
    end
    cur_y = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hblank = 1'b1; vblank = 1'b0; hsync = 1'b1; vsync = 1'b1;
    tick();
    checks++;
    if ({m_hsync, m_vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_sync: got %b want 11", {m_hsync, m_vsync});
    end
    checks++;
    if (m_rgb !== 3'b000) begin
      errors++; $display("FAIL reset_rgb: got %b want 000", m_rgb);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if ({m_hsync, m_vsync} !== 2'b11) begin
      errors++; $display("FAIL post_reset_sync: got %b want 11", {m_hsync, m_vsync});
    end
    checks++;
    if (m_rgb !== 3'b000 || c_rgb !== 3'b000) begin
      errors++; $display("FAIL post_reset_rgb: got %b/%b want 000/000", m_rgb, c_rgb);
    end
    cur_y = 0;
  endtask

  task automatic test_frame0();
    int xs [5] = '{320, 336, 337, 304, 303};
    logic [2:0] ex [5] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
    goto_line(240);
    scan_line(345);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ml[xs[i]] !== ex[i]) begin
        errors++; $display("FAIL frame0 (%0d,240): got %b want %b", xs[i], ml[xs[i]], ex[i]);
      end
    end
    goto_line(256);
    scan_line(330);
    checks++;
    if (ml[320] !== 3'b001) begin
      errors++; $display("FAIL frame0 (320,256): got %b want 001", ml[320]);
    end
    scan_line(330);
    checks++;
    if (ml[320] !== 3'b000) begin
      errors++; $display("FAIL frame0 (320,257): got %b want 000", ml[320]);
    end
  endtask

  task automatic test_sync_align();
    logic hs_o [0:15];
    logic vs_o [0:15];
    int idx [7] = '{4, 5, 8, 9, 6, 7, 8};
    logic ex [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      tick();
      hsync = !(i >= 2 && i < 6);
      vsync = !(i == 4);
      hs_o[i] = m_hsync;
      vs_o[i] = m_vsync;
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k < 4) begin
        if (hs_o[idx[k]] !== ex[k]) begin
          errors++; $display("FAIL hsync_align cyc %0d: got %b want %b", idx[k], hs_o[idx[k]], ex[k]);
        end
      end else begin
        if (vs_o[idx[k]] !== ex[k]) begin
          errors++; $display("FAIL vsync_align cyc %0d: got %b want %b", idx[k], vs_o[idx[k]], ex[k]);
        end
      end
    end
  endtask

  task automatic test_one_vblank();
    int xs [5] = '{322, 338, 339, 306, 305};
    logic [2:0] ex [5] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
    advance_frames(1);
    goto_line(242);
    scan_line(345);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ml[xs[i]] !== ex[i]) begin
        errors++; $display("FAIL frame1 (%0d,242): got %b want %b", xs[i], ml[xs[i]], ex[i]);
      end
    end
  endtask

  // Frame 112 bounced y (col 010); frame 152 clamps x to 623 (col 011).
  task automatic test_right_wall();
    int ys [3] = '{385, 383, 381};
    int xs [3][4] = '{'{622, 638, 606, 605}, '{623, 622, 607, 606}, '{621, 605, 604, 637}};
    logic [2:0] ex [3][4] = '{'{3'b010, 3'b010, 3'b010, 3'b000},
                              '{3'b011, 3'b011, 3'b011, 3'b000},
                              '{3'b011, 3'b011, 3'b000, 3'b011}};
    for (int f = 0; f < 3; f++) begin
      advance_frames((f == 0) ? 150 : 1);
      goto_line(ys[f]);
      scan_line(640);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ml[xs[f][i]] !== ex[f][i]) begin
          errors++;
          $display("FAIL wall (%0d,%0d): got %b want %b", xs[f][i], ys[f], ml[xs[f][i]], ex[f][i]);
        end
      end
    end
  endtask

  // Small instance: corner hits at frames 15,43,...,155 (col 111), 183 (wraps to 001).
  task automatic test_corner();
    int adv [3] = '{2, 28, 1};
    int ys [3] = '{4, 59, 57};
    int xs [3][4] = '{'{4, 8, 9, 1}, '{59, 55, 54, 56}, '{57, 61, 62, 52}};
    logic [2:0] ex [3][4] = '{'{3'b111, 3'b111, 3'b000, 3'b111},
                              '{3'b001, 3'b001, 3'b000, 3'b001},
                              '{3'b001, 3'b001, 3'b000, 3'b000}};
    for (int f = 0; f < 3; f++) begin
      advance_frames(adv[f]);
      goto_line(ys[f]);
      scan_line(64);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cl[xs[f][i]] !== ex[f][i]) begin
          errors++;
          $display("FAIL corner (%0d,%0d): got %b want %b", xs[f][i], ys[f], cl[xs[f][i]], ex[f][i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_line();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cur_y = 0;
    goto_line(240);
    for (int i = 0; i < 324; i++) begin
      tick();
      hblank = 1'b0;
      hsync = (i >= 300) ? 1'b0 : 1'b1;
      vsync = (i >= 300) ? 1'b0 : 1'b1;
    end
    checks++;
    if ({m_rgb, m_hsync, m_vsync} !== 5'b001_00) begin
      errors++; $display("FAIL pre_reset (320,240): got %b want 00100", {m_rgb, m_hsync, m_vsync});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_rgb, m_hsync, m_vsync} !== 5'b000_11) begin
      errors++; $display("FAIL mid_line_reset: got %b want 00011", {m_rgb, m_hsync, m_vsync});
    end
    hsync = 1'b1; vsync = 1'b1; hblank = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cur_y = 0;
  endtask

  task automatic test_border();
    logic [2:0] exp_edge;
`ifdef BALL_BORDER_EN
    exp_edge = 3'b111;
`else
    exp_edge = 3'b000;
`endif
    goto_line(5);
    scan_line(16);
    checks++;
    if (ml[0] !== exp_edge) begin
      errors++; $display("FAIL border (0,5): got %b want %b", ml[0], exp_edge);
    end
    checks++;
    if (ml[1] !== 3'b000) begin
      errors++; $display("FAIL border (1,5): got %b want 000", ml[1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame0();
    test_sync_align();
    test_one_vblank();
    test_right_wall();
    test_corner();
    test_reset_mid_line();
    test_border();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
